// File: rtl/sync_fifo.sv
// Single-clock FIFO with FWFT or standard read mode, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.

module simple_dual_port_ram #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             wclk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rclk,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge wclk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   always_ff @(posedge rclk) begin
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

module sync_fifo #(
   parameter int unsigned WIDTH         = 256,
   parameter int unsigned DEPTH         = 1024,
   parameter int unsigned FWFT          = 1,
   parameter int unsigned AFULL_THRESH  = DEPTH - 4,
   parameter int unsigned AEMPTY_THRESH = 4,
   localparam int unsigned ADDR_WIDTH   = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  wen,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  ren,
   output logic [WIDTH-1:0]      rdata,
   output logic                  rvalid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned AW = ADDR_WIDTH;
   localparam int unsigned CW = AW + 1;
   localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW:0] AF_C    = CW'(AFULL_THRESH);
   localparam logic [AW:0] AE_C    = CW'(AEMPTY_THRESH);

   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
   logic             full_q, full_d, afull_q, afull_d;
   logic             empty_q, empty_d, aempty_q, aempty_d;
   logic             rvalid_q, rvalid_d, ovf_q, ovf_d, unf_q, unf_d;
   logic             head_v_q, head_v_d, rd_seen_q, rd_seen_d;
   logic             clr, wr_acc, rd_acc, ram_has, ram_re;
   logic [WIDTH-1:0] ram_dout;

   always_comb begin
      clr     = reset | flush;
      wr_acc  = wen & ~full_q & ~clr;
      rd_acc  = ren & ~empty_q & ~clr;
      ram_has = (wptr_q != rptr_q);

      // In FWFT mode the RAM read register is the head register: refill it
      // whenever it is free or being popped, so back-to-back pops never bubble.
      if (FWFT != 0) ram_re = ~clr & ram_has & (~head_v_q | rd_acc);
      else           ram_re = rd_acc;

      wptr_d    = wptr_q + CW'(wr_acc);
      rptr_d    = rptr_q + CW'(ram_re);
      count_d   = count_q + CW'(wr_acc) - CW'(rd_acc);
      head_v_d  = (FWFT != 0) ? (ram_re | (head_v_q & ~rd_acc)) : 1'b0;
      rd_seen_d = rd_seen_q | ram_re;
      empty_d   = (FWFT != 0) ? ~head_v_d : (count_d == '0);
      rvalid_d  = (FWFT != 0) ? head_v_d : rd_acc;
      full_d    = (count_d == DEPTH_C);
      afull_d   = (count_d >= AF_C);
      aempty_d  = (count_d <= AE_C);
      ovf_d     = ovf_q | (wen & full_q);
      unf_d     = unf_q | (ren & empty_q);

      if (flush) begin
         wptr_d    = '0;
         rptr_d    = '0;
         count_d   = '0;
         head_v_d  = 1'b0;
         rd_seen_d = 1'b0;
         empty_d   = 1'b1;
         rvalid_d  = 1'b0;
         full_d    = 1'b0;
         afull_d   = (AF_C == '0);
         aempty_d  = 1'b1;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         head_v_q  <= 1'b0;
         rd_seen_q <= 1'b0;
         empty_q   <= 1'b1;
         rvalid_q  <= 1'b0;
         full_q    <= 1'b0;
         afull_q   <= (AF_C == '0);
         aempty_q  <= 1'b1;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         head_v_q  <= head_v_d;
         rd_seen_q <= rd_seen_d;
         empty_q   <= empty_d;
         rvalid_q  <= rvalid_d;
         full_q    <= full_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   simple_dual_port_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .wclk  (clk),
      .we    (wr_acc),
      .waddr (wptr_q[AW-1:0]),
      .wdata (wdata),
      .rclk  (clk),
      .re    (ram_re),
      .raddr (rptr_q[AW-1:0]),
      .rdata (ram_dout)
   );

   // The RAM read register is not reset, so mask it until a read has loaded it.
   assign rdata        = rd_seen_q ? ram_dout : '0;
   assign rvalid       = rvalid_q;
   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule
